// File: rtl/write_arbiter.sv
// AXI write-path arbiter for three masters: grants one master, decodes AWADDR to a slave index and
// holds the grant through AW/W/B. Define WARB_RR_EN for round-robin instead of fixed priority M1>M2>M0.
module write_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] AWADDR_M0,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [ADDR_W-1:0] AWADDR_M2,
    input  logic [LEN_W-1:0]  AWLEN_M0,
    input  logic [LEN_W-1:0]  AWLEN_M1,
    input  logic [LEN_W-1:0]  AWLEN_M2,
    input  logic              AWVALID_M0,
    input  logic              AWVALID_M1,
    input  logic              AWVALID_M2,
    input  logic              AWREADY_M0,
    input  logic              AWREADY_M1,
    input  logic              AWREADY_M2,
    input  logic              WVALID_M0,
    input  logic              WVALID_M1,
    input  logic              WVALID_M2,
    input  logic              WREADY_M0,
    input  logic              WREADY_M1,
    input  logic              WREADY_M2,
    input  logic              WLAST_M0,
    input  logic              WLAST_M1,
    input  logic              WLAST_M2,
    input  logic              BVALID_M0,
    input  logic              BVALID_M1,
    input  logic              BVALID_M2,
    input  logic              BREADY_M0,
    input  logic              BREADY_M1,
    input  logic              BREADY_M2,
    output logic              W_GNT_VALID,
    output logic [1:0]        W_GNT_MST,
    output logic [3:0]        W_GNT_SLV,
    output logic              W_BUSY,
    output logic              W_LEN_ERR
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    // Per-master signals gathered into 4-entry vectors; entry 3 is a dead slot so a 2-bit index is always in range.
    logic [3:0]       awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [15:0]      awhi  [4];
    logic [LEN_W-1:0] awlen [4];
    logic             unused_addr_lo;

    assign awvalid = {1'b0, AWVALID_M2, AWVALID_M1, AWVALID_M0};
    assign awready = {1'b0, AWREADY_M2, AWREADY_M1, AWREADY_M0};
    assign wvalid  = {1'b0, WVALID_M2,  WVALID_M1,  WVALID_M0};
    assign wready  = {1'b0, WREADY_M2,  WREADY_M1,  WREADY_M0};
    assign wlast   = {1'b0, WLAST_M2,   WLAST_M1,   WLAST_M0};
    assign bvalid  = {1'b0, BVALID_M2,  BVALID_M1,  BVALID_M0};
    assign bready  = {1'b0, BREADY_M2,  BREADY_M1,  BREADY_M0};
    assign awhi[0] = AWADDR_M0[31:16];
    assign awhi[1] = AWADDR_M1[31:16];
    assign awhi[2] = AWADDR_M2[31:16];
    assign awhi[3] = '0;
    assign awlen[0] = AWLEN_M0;
    assign awlen[1] = AWLEN_M1;
    assign awlen[2] = AWLEN_M2;
    assign awlen[3] = '0;
    assign unused_addr_lo = ^{AWADDR_M0[15:0], AWADDR_M1[15:0], AWADDR_M2[15:0]};

    function automatic logic [3:0] decode(input logic [15:0] hi);
        logic [3:0] s;
        case (hi)
            16'h0000: s = 4'd0;
            16'h0001: s = 4'd1;
            16'h0002: s = 4'd2;
            16'h1000: s = 4'd3;
            16'h1001: s = 4'd4;
            16'h0010: s = 4'd6;
            16'h0003: s = 4'd7;
            default:  s = (hi[15:8] == 8'h20) ? 4'd5 : 4'd8;
        endcase
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       mst_q, mst_d;
    logic [3:0]       slv_q, slv_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             wlast_seen_q, wlast_seen_d;
    logic             err_done_q, err_done_d;
    logic             len_err_q, len_err_d;
    logic [1:0]       sel;

`ifdef WARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    // Search ptr+1, ptr+2, ptr (mod 3); first requester wins.
    always_comb begin
        logic       found;
        logic [2:0] sum;
        logic [1:0] c;
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            sum = {1'b0, ptr_q} + 3'(k);
            c   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && awvalid[c]) begin
                sel   = c;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel = 2'd0;
        if (awvalid[1])      sel = 2'd1;
        else if (awvalid[2]) sel = 2'd2;
    end
`endif

    logic           aw_hs, w_hs, b_hs, count_w;
    logic [LEN_W:0] cnt_inc, exp_beats;

    assign aw_hs     = awvalid[mst_q] & awready[mst_q];
    assign w_hs      = wvalid[mst_q] & wready[mst_q];
    assign b_hs      = bvalid[mst_q] & bready[mst_q];
    assign count_w   = w_hs && ((state_q == ADDR && !wlast_seen_q) || state_q == DATA);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign exp_beats = {1'b0, len_q} + 1'b1;

    always_comb begin
        state_d      = state_q;
        mst_d        = mst_q;
        slv_d        = slv_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        wlast_seen_d = wlast_seen_q;
        err_done_d   = err_done_q;
        len_err_d    = 1'b0;
`ifdef WARB_RR_EN
        ptr_d        = ptr_q;
`endif
        // A mismatched WLAST or the first overrun beat raises one pulse per grant.
        if (count_w) begin
            cnt_d = cnt_inc;
            if (!err_done_q && ((wlast[mst_q] && cnt_inc != exp_beats) ||
                                (!wlast[mst_q] && cnt_inc == exp_beats + 1'b1))) begin
                len_err_d  = 1'b1;
                err_done_d = 1'b1;
            end
        end
        case (state_q)
            IDLE: if (|awvalid) begin
                state_d      = ADDR;
                mst_d        = sel;
                slv_d        = decode(awhi[sel]);
                len_d        = awlen[sel];
                cnt_d        = '0;
                wlast_seen_d = 1'b0;
                err_done_d   = 1'b0;
`ifdef WARB_RR_EN
                ptr_d        = sel;
`endif
            end
            ADDR: begin
                if (count_w && wlast[mst_q]) wlast_seen_d = 1'b1;
                if (aw_hs)
                    state_d = (wlast_seen_q || (count_w && wlast[mst_q])) ? RESP : DATA;
            end
            DATA: if (w_hs && wlast[mst_q]) state_d = RESP;
            RESP: if (b_hs) begin
                state_d = IDLE;
                mst_d   = 2'd0;
                slv_d   = 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            mst_q        <= 2'd0;
            slv_q        <= 4'd0;
            len_q        <= '0;
            cnt_q        <= '0;
            wlast_seen_q <= 1'b0;
            err_done_q   <= 1'b0;
            len_err_q    <= 1'b0;
`ifdef WARB_RR_EN
            ptr_q        <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            mst_q        <= mst_d;
            slv_q        <= slv_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            wlast_seen_q <= wlast_seen_d;
            err_done_q   <= err_done_d;
            len_err_q    <= len_err_d;
`ifdef WARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign W_GNT_VALID = (state_q != IDLE);
    assign W_BUSY      = (state_q != IDLE);
    assign W_GNT_MST   = mst_q;
    assign W_GNT_SLV   = slv_q;
    assign W_LEN_ERR   = len_err_q;
endmodule

// File: tb/tb_write_arbiter.sv
// Directed bench for write_arbiter: reset, single write, decode sweep, contention, early W, length errors.
module tb_write_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] awaddr [3];
    logic [3:0]  awlen  [3];
    logic [2:0]  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        W_GNT_VALID, W_BUSY, W_LEN_ERR;
    logic [1:0]  W_GNT_MST;
    logic [3:0]  W_GNT_SLV;
    int          checks = 0;
    int          failures = 0;

    always #5 ACLK = ~ACLK;

    write_arbiter #(.ADDR_W(32), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR_M0(awaddr[0]), .AWADDR_M1(awaddr[1]), .AWADDR_M2(awaddr[2]),
        .AWLEN_M0(awlen[0]), .AWLEN_M1(awlen[1]), .AWLEN_M2(awlen[2]),
        .AWVALID_M0(awvalid[0]), .AWVALID_M1(awvalid[1]), .AWVALID_M2(awvalid[2]),
        .AWREADY_M0(awready[0]), .AWREADY_M1(awready[1]), .AWREADY_M2(awready[2]),
        .WVALID_M0(wvalid[0]), .WVALID_M1(wvalid[1]), .WVALID_M2(wvalid[2]),
        .WREADY_M0(wready[0]), .WREADY_M1(wready[1]), .WREADY_M2(wready[2]),
        .WLAST_M0(wlast[0]), .WLAST_M1(wlast[1]), .WLAST_M2(wlast[2]),
        .BVALID_M0(bvalid[0]), .BVALID_M1(bvalid[1]), .BVALID_M2(bvalid[2]),
        .BREADY_M0(bready[0]), .BREADY_M1(bready[1]), .BREADY_M2(bready[2]),
        .W_GNT_VALID(W_GNT_VALID), .W_GNT_MST(W_GNT_MST), .W_GNT_SLV(W_GNT_SLV),
        .W_BUSY(W_BUSY), .W_LEN_ERR(W_LEN_ERR)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        awvalid = '0; awready = '0; wvalid = '0; wready = '0;
        wlast = '0; bvalid = '0; bready = '0;
        for (int i = 0; i < 3; i++) begin
            awaddr[i] = '0;
            awlen[i]  = '0;
        end
    endtask

    // Full transaction: request, AW handshake, nbeats W beats (WLAST on the final one), B handshake.
    task automatic run_txn(input string tag, input int m, input logic [31:0] addr,
                           input logic [3:0] len, input int nbeats, input int exp_slv,
                           input int exp_err);
        int errs;
        errs = 0;
        awaddr[m] = addr; awlen[m] = len; awvalid[m] = 1'b1;
        chk({tag, "_pre_valid"}, W_GNT_VALID, 0);
        step();
        chk({tag, "_gnt_valid"}, W_GNT_VALID, 1);
        chk({tag, "_gnt_mst"}, W_GNT_MST, m);
        chk({tag, "_gnt_slv"}, W_GNT_SLV, exp_slv);
        awready[m] = 1'b1;
        step();
        awvalid[m] = 1'b0; awready[m] = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wvalid[m] = 1'b1; wready[m] = 1'b1; wlast[m] = (i == nbeats - 1);
            step();
            errs += int'(W_LEN_ERR);
        end
        wvalid[m] = 1'b0; wready[m] = 1'b0; wlast[m] = 1'b0;
        chk({tag, "_resp_busy"}, W_BUSY, 1);
        chk({tag, "_resp_slv"}, W_GNT_SLV, exp_slv);
        bvalid[m] = 1'b1; bready[m] = 1'b1;
        step();
        errs += int'(W_LEN_ERR);
        bvalid[m] = 1'b0; bready[m] = 1'b0;
        chk({tag, "_idle_valid"}, W_GNT_VALID, 0);
        chk({tag, "_idle_slv"}, W_GNT_SLV, 0);
        chk({tag, "_len_err_cycles"}, errs, exp_err);
    endtask

    initial begin
        int exp_order [4];
        clear_inputs();
        step();
        step();
        chk("rst_valid", W_GNT_VALID, 0);
        chk("rst_busy", W_BUSY, 0);
        chk("rst_mst", W_GNT_MST, 0);
        chk("rst_slv", W_GNT_SLV, 0);
        chk("rst_err", W_LEN_ERR, 0);
        ARESETn = 1'b1;
        step();
        chk("post_rst_valid", W_GNT_VALID, 0);

        run_txn("single", 1, 32'h0002_0010, 4'd3, 4, 2, 0);

        run_txn("dec_wdt",  2, 32'h1001_0000, 4'd0, 1, 4, 0);
        run_txn("dec_dram", 2, 32'h2000_0040, 4'd0, 1, 5, 0);
        run_txn("dec_epu",  2, 32'h0010_0000, 4'd0, 1, 6, 0);
        run_txn("dec_dma",  2, 32'h0003_0000, 4'd0, 1, 7, 0);
        run_txn("dec_def",  2, 32'h3000_0000, 4'd0, 1, 8, 0);
        run_txn("dec_rom",  0, 32'h0000_1234, 4'd0, 1, 0, 0);
        run_txn("dec_sctl", 0, 32'h1000_0000, 4'd0, 1, 3, 0);

        run_txn("lenerr_short", 1, 32'h0001_0000, 4'd3, 2, 1, 1);
        run_txn("lenerr_over",  0, 32'h0002_0000, 4'd0, 3, 2, 1);

        // Early W: WLAST beat accepted in ADDR before AWREADY.
        awaddr[2] = 32'h0002_0000; awlen[2] = 4'd0; awvalid[2] = 1'b1;
        step();
        chk("early_gnt_mst", W_GNT_MST, 2);
        wvalid[2] = 1'b1; wready[2] = 1'b1; wlast[2] = 1'b1;
        step();
        chk("early_err_w", W_LEN_ERR, 0);
        wvalid[2] = 1'b0; wready[2] = 1'b0; wlast[2] = 1'b0; awready[2] = 1'b1;
        step();
        chk("early_err_aw", W_LEN_ERR, 0);
        awvalid[2] = 1'b0; awready[2] = 1'b0; bvalid[2] = 1'b1; bready[2] = 1'b1;
        step();
        bvalid[2] = 1'b0; bready[2] = 1'b0;
        chk("early_resp_to_idle", W_GNT_VALID, 0);
        chk("early_err_b", W_LEN_ERR, 0);

        // Contention: all three request continuously with 1-beat bursts.
`ifdef WARB_RR_EN
        exp_order = '{1, 2, 0, 1};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 3; i++) begin
            awaddr[i] = 32'h0001_0000; awlen[i] = 4'd0;
        end
        awvalid = 3'b111;
        for (int t = 0; t < 4; t++) begin
            int g;
            g = exp_order[t];
            step();
            chk($sformatf("cont%0d_valid", t), W_GNT_VALID, 1);
            chk($sformatf("cont%0d_mst", t), W_GNT_MST, g);
            awready[g] = 1'b1; wvalid[g] = 1'b1; wready[g] = 1'b1; wlast[g] = 1'b1;
            step();
            awready = '0; wvalid = '0; wready = '0; wlast = '0;
            chk($sformatf("cont%0d_resp_mst", t), W_GNT_MST, g);
            bvalid[g] = 1'b1; bready[g] = 1'b1;
            step();
            bvalid = '0; bready = '0;
            chk($sformatf("cont%0d_idle", t), W_GNT_VALID, 0);
        end
        awvalid = '0;
        step();

        // Asynchronous reset in the middle of DATA.
        awaddr[1] = 32'h0001_0000; awlen[1] = 4'd3; awvalid[1] = 1'b1;
        step();
        awready[1] = 1'b1;
        step();
        awvalid[1] = 1'b0; awready[1] = 1'b0;
        wvalid[1] = 1'b1; wready[1] = 1'b1;
        step();
        chk("mid_busy_before_rst", W_BUSY, 1);
        #2 ARESETn = 1'b0;
        #1;
        chk("arst_valid", W_GNT_VALID, 0);
        chk("arst_busy", W_BUSY, 0);
        chk("arst_mst", W_GNT_MST, 0);
        chk("arst_slv", W_GNT_SLV, 0);
        clear_inputs();
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        step();
        chk("arst_release_idle", W_GNT_VALID, 0);
        run_txn("after_rst", 1, 32'h0002_0000, 4'd1, 2, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
